// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: instruction memory read port plus redirect input and the
// valid/ready instruction stream toward decode.
interface instruction_fetch_unit_if;
    logic [63:0] mem_address;
    logic        mem_read_en;
    logic [31:0] mem_read_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [63:0] out_pc;
    logic        halted;

    // Fetch unit side
    modport master (
        output mem_address, mem_read_en, out_valid, out_insn, out_pc, halted,
        input  mem_read_data, redirect_valid, redirect_pc, out_ready
    );

    // Memory / decode / branch-resolution side
    modport slave (
        input  mem_address, mem_read_en, out_valid, out_insn, out_pc, halted,
        output mem_read_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory
// combinationally, buffers {pc, insn} pairs in a small FIFO toward decode,
// flushes on redirect and stops fetching once the HALT encoding is seen.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | just out of reset, no fetch yet
// RUN     | fetching whenever the FIFO has (or is freeing) room
// HALTED  | HALT word fetched; waits for a redirect
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter logic [63:0] PC_STEP   = 64'd2,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] HALT_INSN = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    instruction_fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]    state_q;
    logic [63:0]   pc_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic [31:0]   insn_mem [DEPTH];
    logic [63:0]   pc_mem   [DEPTH];

    logic fetch;
    logic pop;
    logic is_halt;

    // A redirect blocks both fetch and pop; the flush wins that cycle.
    assign pop     = (count_q != '0) & bus.out_ready & ~bus.redirect_valid;
    assign fetch   = (state_q == RUN) & ~bus.redirect_valid & ((count_q < FULL_COUNT) | pop);
    assign is_halt = (bus.mem_read_data == HALT_INSN);

    assign bus.mem_address = pc_q;
    assign bus.mem_read_en = fetch;
    assign bus.out_valid   = (count_q != '0);
    assign bus.out_insn    = bus.out_valid ? insn_mem[rd_ptr_q] : 32'd0;
    assign bus.out_pc      = bus.out_valid ? pc_mem[rd_ptr_q]   : 64'd0;
    assign bus.halted      = (state_q == HALTED);

    // Control state: FSM, PC and FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.redirect_valid) begin
            state_q  <= RUN;
            pc_q     <= bus.redirect_pc & ~64'd1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (state_q == IDLE) begin
                state_q <= RUN;
            end else if (fetch && is_halt) begin
                state_q <= HALTED;
            end
            if (fetch && !is_halt) begin
                pc_q <= pc_q + PC_STEP;
            end
            if (fetch) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (fetch && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !fetch) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // FIFO storage; contents are only visible through count, so no reset needed
    always_ff @(posedge clk) begin
        if (fetch) begin
            insn_mem[wr_ptr_q] <= bus.mem_read_data;
            pc_mem[wr_ptr_q]   <= pc_q;
        end
    end
endmodule
